// File: rtl/instr_fetch_sequencer.sv
// Multicycle instruction fetch stage: reads words over an imem req/ack handshake,
// holds them in IR, and presents decoded fields to the control unit until the next PC arrives.
module instr_fetch_sequencer #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [4:0]      func,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [31:0]     imm32,
  output logic [PC_W-1:0] joff,
  output logic [1:0]      insType,
  output logic            stopOut,
  output logic [PC_W-1:0] pc_cur,
  input  logic            pc_wr,
  input  logic [PC_W-1:0] pc_next,
  output logic            busy,
  output logic            halted,
  output logic            fetch_err
);

  localparam int unsigned TCNT_W    = 16;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DEC,
    S_WAIT_PC,
    S_HALT,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [TCNT_W-1:0] tcnt;
  logic              pc_load;

  // Next-state and PC-load decision
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack)               state_nxt = S_WAIT_DEC;
        else if (tcnt == TCNT_LAST) state_nxt = S_ERR;
      end
      S_WAIT_DEC: begin
        if (dec_ready) begin
          if (ir[0]) begin
            state_nxt = S_HALT;
          end else if (pc_wr) begin
            pc_load   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WAIT_PC;
          end
        end
      end
      S_WAIT_PC: begin
        if (pc_wr) begin
          pc_load   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // State, datapath registers and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      tcnt      <= '0;
      imem_req  <= 1'b0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (pc_load) pc <= pc_next;
      // Counter idles at zero outside FETCH, so every FETCH entry starts from zero
      if (state != S_FETCH)  tcnt <= '0;
      else if (!imem_ack)    tcnt <= tcnt + TCNT_W'(1);
      imem_req  <= (state_nxt == S_FETCH);
      dec_valid <= (state_nxt == S_WAIT_DEC);
      busy      <= (state_nxt == S_FETCH) || (state_nxt == S_WAIT_DEC) ||
                   (state_nxt == S_WAIT_PC);
      halted    <= (state_nxt == S_HALT);
      fetch_err <= (state_nxt == S_ERR);
    end
  end

  assign imem_addr = pc;
  assign pc_cur    = pc;

  // Field slices of IR, stable for as long as IR holds the instruction
  assign func    = ir[31:27];
  assign rd      = ir[26:23];
  assign rs1     = ir[22:19];
  assign rs2     = ir[18:15];
  assign imm32   = 32'($signed(ir[16:3]));
  assign joff    = PC_W'($signed(ir[26:3]));
  assign insType = ir[2:1];
  assign stopOut = ir[0];

endmodule
